// File: rtl/reg_bank_write_sequencer_if.sv
// Request channel into the register-bank write sequencer.
// The channel carries the valid/ready handshake, the access mode, the register index and the data.
interface reg_bank_write_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_mode;
  logic [IDX_W-1:0]  in_idx;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, in_mode, in_idx, in_data, input in_ready);
  modport slave  (input in_valid, in_mode, in_idx, in_data, output in_ready);
endinterface

// File: rtl/reg_bank_write_sequencer.sv
// Buffered write-port sequencer for the general-purpose register bank.
// Queued requests become registered byte-lane write enables, and the queue contents drive a pending-lane scoreboard.
module reg_bank_write_sequencer #(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 8,
  parameter int NUM_SPLIT = 4,
  parameter int IDX_W     = 3,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  reg_bank_write_sequencer_if.slave req,
  input  logic                   issue_en,
  output logic [NUM_REGS-1:0]    we_lo,
  output logic [NUM_REGS-1:0]    we_hi,
  output logic [DATA_W-1:0]      wdata,
  output logic [NUM_REGS-1:0]    pend_lo,
  output logic [NUM_REGS-1:0]    pend_hi,
  output logic                   err,
  output logic                   err_sticky,
  output logic [IDX_W:0]         level
);

  localparam int B     = DATA_W / 2;
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    MODE_LO   = 2'b00,
    MODE_HI   = 2'b01,
    MODE_WORD = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  function automatic logic is_legal(input logic [1:0] mode, input logic [IDX_W-1:0] idx);
    logic ok;
    ok = 1'b1;
    if (mode == MODE_RSVD) ok = 1'b0;
    if (int'(idx) >= NUM_REGS) ok = 1'b0;
    if (mode != MODE_WORD && int'(idx) >= NUM_SPLIT) ok = 1'b0;
    return ok;
  endfunction

  // Byte writes replicate the byte into both lanes, so the bank never needs a lane shifter.
  function automatic logic [DATA_W-1:0] align_data(input logic [1:0] mode, input logic [DATA_W-1:0] d);
    if (mode == MODE_WORD) return d;
    return {d[B-1:0], d[B-1:0]};
  endfunction

  logic [IDX_W-1:0]  mem_idx  [DEPTH];
  logic              mem_lo   [DEPTH];
  logic              mem_hi   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, accept, legal, push, bad, pop;
  logic [DEPTH-1:0] slot_vld;
  logic [NUM_REGS-1:0] head_we_lo_p0, head_we_hi_p0;

  assign full         = (count == (PTR_W+1)'(DEPTH));
  assign empty        = (count == '0);
  assign req.in_ready = !full && !flush;
  assign accept       = req.in_valid && req.in_ready;
  assign legal        = is_legal(req.in_mode, req.in_idx);
  assign push         = accept && legal;
  assign bad          = accept && !legal;
  assign pop          = !empty && issue_en && !flush;
  assign level        = (IDX_W+1)'(count);

  // Stage p0: request storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_idx[wr_ptr]  <= req.in_idx;
      mem_lo[wr_ptr]   <= (req.in_mode != MODE_HI);
      mem_hi[wr_ptr]   <= (req.in_mode != MODE_LO);
      mem_data[wr_ptr] <= align_data(req.in_mode, req.in_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // A slot is occupied when its distance from the head, modulo DEPTH, is below the occupancy.
  always_comb begin
    slot_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_vld[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count);
    end
  end

  always_comb begin
    pend_lo = '0;
    pend_hi = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (slot_vld[i] && mem_idx[i] == IDX_W'(r)) begin
          pend_lo[r] = pend_lo[r] | mem_lo[i];
          pend_hi[r] = pend_hi[r] | mem_hi[i];
        end
      end
    end
  end

  always_comb begin
    head_we_lo_p0 = '0;
    head_we_hi_p0 = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (mem_idx[rd_ptr] == IDX_W'(r)) begin
        head_we_lo_p0[r] = mem_lo[rd_ptr];
        head_we_hi_p0[r] = mem_hi[rd_ptr];
      end
    end
  end

  // Stage p1: registered write-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_lo      <= '0;
      we_hi      <= '0;
      wdata      <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      we_lo <= pop ? head_we_lo_p0 : '0;
      we_hi <= pop ? head_we_hi_p0 : '0;
      if (pop) wdata <= mem_data[rd_ptr];
      err <= bad;
      if (flush)    err_sticky <= 1'b0;
      else if (bad) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_bank_write_sequencer.sv
// Directed bench for reg_bank_write_sequencer: every scenario task checks against hand-computed values.
module tb_reg_bank_write_sequencer;
  localparam int DATA_W = 16, NUM_REGS = 8, NUM_SPLIT = 4, IDX_W = 4, DEPTH = 4;

  logic clk, rst_n, flush, issue_en;
  logic [NUM_REGS-1:0] we_lo, we_hi, pend_lo, pend_hi;
  logic [DATA_W-1:0]   wdata;
  logic                err, err_sticky;
  logic [IDX_W:0]      level;
  int n_chk = 0;
  int n_fail = 0;

  reg_bank_write_sequencer_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) rq ();

  reg_bank_write_sequencer #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_SPLIT(NUM_SPLIT), .IDX_W(IDX_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req(rq), .issue_en(issue_en),
    .we_lo(we_lo), .we_hi(we_hi), .wdata(wdata), .pend_lo(pend_lo), .pend_hi(pend_hi),
    .err(err), .err_sticky(err_sticky), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [IDX_W-1:0] i, input logic [DATA_W-1:0] d);
    rq.in_valid = v; rq.in_mode = m; rq.in_idx = i; rq.in_data = d;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_chk++; if (we_lo !== 8'h00 || we_hi !== 8'h00) begin n_fail++; $display("FAIL reset_we: got %h/%h want 00/00", we_lo, we_hi); end
    n_chk++; if (wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_wdata: got %h want 0000", wdata); end
    n_chk++; if (err !== 1'b0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b/%b want 0/0", err, err_sticky); end
    n_chk++; if (pend_lo !== 8'h00 || pend_hi !== 8'h00) begin n_fail++; $display("FAIL reset_pend: got %h/%h want 00/00", pend_lo, pend_hi); end
    n_chk++; if (rq.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", rq.in_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_word_write();
    issue_en = 1'b1;
    drive(1'b1, 2'b10, 4'd2, 16'hBEEF);
    step();
    drive(1'b0, 2'b00, 4'd0, 16'h0000);
    n_chk++; if (level !== 5'd1) begin n_fail++; $display("FAIL word_level_q: got %0d want 1", level); end
    n_chk++; if (pend_lo !== 8'h04 || pend_hi !== 8'h04) begin n_fail++; $display("FAIL word_pend_q: got %h/%h want 04/04", pend_lo, pend_hi); end
    n_chk++; if (we_lo !== 8'h00) begin n_fail++; $display("FAIL word_we_early: got %h want 00", we_lo); end
    step();
    n_chk++; if (we_lo !== 8'h04 || we_hi !== 8'h04) begin n_fail++; $display("FAIL word_we: got %h/%h want 04/04", we_lo, we_hi); end
    n_chk++; if (wdata !== 16'hBEEF) begin n_fail++; $display("FAIL word_wdata: got %h want beef", wdata); end
    n_chk++; if (pend_lo !== 8'h00 || pend_hi !== 8'h00 || level !== 5'd0) begin n_fail++; $display("FAIL word_pend_done: got %h/%h lvl %0d want 00/00 lvl 0", pend_lo, pend_hi, level); end
    step();
    n_chk++; if (we_lo !== 8'h00 || we_hi !== 8'h00 || wdata !== 16'hBEEF) begin n_fail++; $display("FAIL word_pulse_end: got %h/%h %h want 00/00 beef", we_lo, we_hi, wdata); end
  endtask

  task automatic test_high_byte();
    drive(1'b1, 2'b01, 4'd3, 16'h0012);
    step();
    drive(1'b0, 2'b00, 4'd0, 16'h0000);
    n_chk++; if (pend_hi !== 8'h08 || pend_lo !== 8'h00) begin n_fail++; $display("FAIL hi_pend: got %h/%h want 00/08", pend_lo, pend_hi); end
    step();
    n_chk++; if (we_hi !== 8'h08 || we_lo !== 8'h00) begin n_fail++; $display("FAIL hi_we: got %h/%h want 00/08", we_lo, we_hi); end
    n_chk++; if (wdata !== 16'h1212) begin n_fail++; $display("FAIL hi_wdata: got %h want 1212", wdata); end
    step();
  endtask

  task automatic test_illegal();
    logic [1:0]       m [3] = '{2'b00, 2'b11, 2'b10};
    logic [IDX_W-1:0] ix [3] = '{4'd5, 4'd0, 4'd9};
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, m[k], ix[k], 16'h5A5A);
      n_chk++; if (rq.in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready_%0d: got %b want 1", k, rq.in_ready); end
      step();
      drive(1'b0, 2'b00, 4'd0, 16'h0000);
      n_chk++; if (err !== 1'b1 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL illegal_err_%0d: got %b/%b want 1/1", k, err, err_sticky); end
      n_chk++; if (level !== 5'd0 || pend_lo !== 8'h00) begin n_fail++; $display("FAIL illegal_queued_%0d: got lvl %0d pend %h want 0 00", k, level, pend_lo); end
      step();
      n_chk++; if (err !== 1'b0 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse_%0d: got %b/%b want 0/1", k, err, err_sticky); end
      n_chk++; if (we_lo !== 8'h00 || we_hi !== 8'h00) begin n_fail++; $display("FAIL illegal_we_%0d: got %h/%h want 00/00", k, we_lo, we_hi); end
    end
  endtask

  task automatic test_fill();
    logic [1:0]        m  [5] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b10};
    logic [IDX_W-1:0]  ix [5] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd6};
    logic [DATA_W-1:0] d  [5] = '{16'h1111, 16'h0022, 16'h0033, 16'hABCD, 16'h5555};
    logic [7:0]        elo [4] = '{8'h01, 8'h02, 8'h00, 8'h80};
    logic [7:0]        ehi [4] = '{8'h01, 8'h00, 8'h04, 8'h80};
    logic [DATA_W-1:0] ed  [4] = '{16'h1111, 16'h2222, 16'h3333, 16'hABCD};
    issue_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, m[k], ix[k], d[k]);
      step();
      n_chk++; if (level !== 5'(k + 1) || we_lo !== 8'h00) begin n_fail++; $display("FAIL fill_level_%0d: got %0d we %h want %0d 00", k, level, we_lo, k + 1); end
    end
    drive(1'b1, m[4], ix[4], d[4]);
    n_chk++; if (rq.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_full: got %b want 0", rq.in_ready); end
    issue_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      drive(1'b0, 2'b00, 4'd0, 16'h0000);
      n_chk++; if (we_lo !== elo[k] || we_hi !== ehi[k] || wdata !== ed[k]) begin n_fail++; $display("FAIL fill_issue_%0d: got %h/%h %h want %h/%h %h", k, we_lo, we_hi, wdata, elo[k], ehi[k], ed[k]); end
      n_chk++; if (level !== 5'(3 - k)) begin n_fail++; $display("FAIL fill_drain_%0d: got %0d want %0d", k, level, 3 - k); end
    end
    step();
    n_chk++; if (we_lo !== 8'h00 || we_hi !== 8'h00 || level !== 5'd0) begin n_fail++; $display("FAIL fill_fifth_dropped: got %h/%h lvl %0d want 00/00 0", we_lo, we_hi, level); end
  endtask

  task automatic test_scoreboard();
    logic [1:0]        m  [3] = '{2'b00, 2'b00, 2'b10};
    logic [DATA_W-1:0] d  [3] = '{16'h0011, 16'h0022, 16'h3344};
    logic [7:0]        ehi [3] = '{8'h00, 8'h00, 8'h01};
    logic [DATA_W-1:0] ed  [3] = '{16'h1111, 16'h2222, 16'h3344};
    logic [7:0]        pl  [3] = '{8'h01, 8'h01, 8'h00};
    logic [7:0]        ph  [3] = '{8'h01, 8'h01, 8'h00};
    issue_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, m[k], 4'd0, d[k]);
      step();
      n_chk++; if (pend_lo !== 8'h01 || pend_hi !== ehi[k]) begin n_fail++; $display("FAIL sb_fill_%0d: got %h/%h want 01/%h", k, pend_lo, pend_hi, ehi[k]); end
    end
    drive(1'b0, 2'b00, 4'd0, 16'h0000);
    issue_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++; if (we_lo !== 8'h01 || we_hi !== ehi[k] || wdata !== ed[k]) begin n_fail++; $display("FAIL sb_issue_%0d: got %h/%h %h want 01/%h %h", k, we_lo, we_hi, wdata, ehi[k], ed[k]); end
      n_chk++; if (pend_lo !== pl[k] || pend_hi !== ph[k]) begin n_fail++; $display("FAIL sb_pend_%0d: got %h/%h want %h/%h", k, pend_lo, pend_hi, pl[k], ph[k]); end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d   [3] = '{16'hC001, 16'hC002, 16'hC003};
    logic [7:0]        oh  [3] = '{8'h10, 8'h20, 8'h40};
    issue_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b10, 4'(k + 4), d[k]);
      step();
      n_chk++; if (level !== 5'd1) begin n_fail++; $display("FAIL b2b_level_%0d: got %0d want 1", k, level); end
      if (k > 0) begin
        n_chk++; if (we_lo !== oh[k-1] || wdata !== d[k-1]) begin n_fail++; $display("FAIL b2b_issue_%0d: got %h %h want %h %h", k, we_lo, wdata, oh[k-1], d[k-1]); end
      end
    end
    drive(1'b0, 2'b00, 4'd0, 16'h0000);
    step();
    n_chk++; if (we_lo !== 8'h40 || wdata !== 16'hC003 || level !== 5'd0) begin n_fail++; $display("FAIL b2b_last: got %h %h lvl %0d want 40 c003 0", we_lo, wdata, level); end
    step();
  endtask

  task automatic test_flush();
    issue_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b10, 4'(k + 1), 16'h0F00);
      step();
    end
    drive(1'b1, 2'b11, 4'd0, 16'h0000);
    step();
    n_chk++; if (level !== 5'd3 || err !== 1'b1 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got lvl %0d err %b/%b want 3 1/1", level, err, err_sticky); end
    drive(1'b1, 2'b10, 4'd4, 16'h7777);
    flush = 1'b1;
    issue_en = 1'b1;
    #1;
    n_chk++; if (rq.in_ready !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got rdy %b err %b want 0 1", rq.in_ready, err); end
    step();
    flush = 1'b0;
    drive(1'b0, 2'b00, 4'd0, 16'h0000);
    n_chk++; if (level !== 5'd0 || pend_lo !== 8'h00 || pend_hi !== 8'h00) begin n_fail++; $display("FAIL flush_empty: got lvl %0d pend %h/%h want 0 00/00", level, pend_lo, pend_hi); end
    n_chk++; if (err_sticky !== 1'b0 || err !== 1'b0 || we_lo !== 8'h00) begin n_fail++; $display("FAIL flush_clear: got sticky %b err %b we %h want 0 0 00", err_sticky, err, we_lo); end
    step();
    n_chk++; if (we_lo !== 8'h00 || we_hi !== 8'h00 || level !== 5'd0) begin n_fail++; $display("FAIL flush_after: got %h/%h lvl %0d want 00/00 0", we_lo, we_hi, level); end
  endtask

  task automatic test_async_reset();
    issue_en = 1'b0;
    drive(1'b1, 2'b10, 4'd5, 16'h1234);
    step();
    drive(1'b1, 2'b10, 4'd6, 16'h5678);
    step();
    issue_en = 1'b1;
    drive(1'b1, 2'b11, 4'd0, 16'h0000);
    step();
    drive(1'b0, 2'b00, 4'd0, 16'h0000);
    n_chk++; if (we_lo !== 8'h20 || wdata !== 16'h1234 || err !== 1'b1 || level !== 5'd1) begin n_fail++; $display("FAIL arst_pre: got %h %h err %b lvl %0d want 20 1234 1 1", we_lo, wdata, err, level); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (we_lo !== 8'h00 || we_hi !== 8'h00 || wdata !== 16'h0000) begin n_fail++; $display("FAIL arst_we: got %h/%h %h want 00/00 0000", we_lo, we_hi, wdata); end
    n_chk++; if (err !== 1'b0 || err_sticky !== 1'b0 || level !== 5'd0 || pend_lo !== 8'h00) begin n_fail++; $display("FAIL arst_state: got err %b/%b lvl %0d pend %h want 0/0 0 00", err, err_sticky, level, pend_lo); end
    rst_n = 1'b1;
    step();
    n_chk++; if (we_lo !== 8'h00 || level !== 5'd0) begin n_fail++; $display("FAIL arst_lost: got %h lvl %0d want 00 0", we_lo, level); end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    issue_en = 1'b0;
    drive(1'b0, 2'b00, 4'd0, 16'h0000);
    test_reset();
    test_word_write();
    test_high_byte();
    test_illegal();
    test_fill();
    test_scoreboard();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
